// File: rtl/mux_pkg.sv
// Shared constants, output-register state encoding and select-width helper
// for the arbitrated channel mux.
package mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A single-bit select is kept even for degenerate channel counts.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority (lowest index) or round robin
// searching upward from ptr with an explicit wrap at N-1.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int MODE  = ARB_RR,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // Offsets never exceed 2N-2, so one subtraction is enough to wrap.
      idx = (MODE == ARB_RR) ? int'(ptr) + k : k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_idx  = SEL_W'(idx);
        gnt[idx] = en;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/chan_arb_mux.sv
// N-channel arbitrated mux with a single registered output stage; refills on
// the same edge it drains, and asserts no in_ready while stalled or in reset.
module chan_arb_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  parameter  int MODE  = ARB_RR,
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             arb_en;
  logic             arb_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] chan_dat [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign chan_dat[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load_en = (state_q == OUT_EMPTY) || out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset assertion.
  assign arb_en  = load_en && rst_n;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (in_ready),
    .gnt_idx (gnt_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (arb_en) begin
      if (arb_any) begin
        state_d = OUT_FULL;
        dat_d   = chan_dat[gnt_idx];
        sel_d   = gnt_idx;
        if (MODE == ARB_RR) begin
          ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SEL_W'(1);
        end
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      dat_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = dat_q;
  assign out_sel   = sel_q;

endmodule

// File: doc/chan_arb_mux.md
# chan_arb_mux

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output and valid/ready handshake on every port. It generalises the 4-bit 2:1 select mux: the select is generated internally by a fixed-priority or round-robin arbiter instead of being driven externally. It sits between several producer streams and a single consumer, such as a shared bus or a result writeback port.

## Interface
- `WIDTH`, default 4: data bits per channel.
- `N`, default 4: number of input channels, N ≥ 2, need not be a power of 2.
- `MODE`, default 1: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round robin.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in N: channel i presents a beat.
- `in_ready` out N: one-hot or zero; channel i's beat is accepted this cycle.
- `out_data` out WIDTH: registered data of the granted beat.
- `out_sel` out SEL_W: index of the source channel of `out_data`. SEL_W = $clog2(N).
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: consumer accepts the beat.

## Operation
- **Output register states:** two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- **Load enable:** `load_en = !out_valid || out_ready`.
- **Grant:** when `load_en` is high and at least one `in_valid` bit is set, exactly one channel g is granted.
  - `in_ready[g]`=1; all other `in_ready` bits are 0.
  - On the next edge: `out_data` ← channel g data, `out_sel` ← g, `out_valid` ← 1.
- **No request:** when `load_en` is high and `in_valid` is 0, all `in_ready` are 0 and `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- **Stall:** when `load_en` is low (FULL and `out_ready`=0), all `in_ready` are 0 and every output holds.
- **Fixed mode:** g is the lowest index with `in_valid` set. The pointer is unused and stays 0.
- **Round-robin mode:**
  - g is the first index with `in_valid` set, searching from `ptr` upward and wrapping N-1 → 0.
  - On each accepted grant, `ptr` ← (g+1) mod N. The wrap is explicit compare-to-N-1, not a natural overflow.
  - `ptr` does not change on cycles without a grant.
- **Combinational paths:** `in_ready` is combinational from `in_valid`, `ptr`, `out_valid` and `out_ready`. It has no dependency on `in_data`.
- **Upstream rules:**
  - Upstream must hold `in_valid` and `in_data` until accepted.
  - Upstream `in_valid` must not depend combinationally on `in_ready`.
  - The block does not check either rule.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0, so `in_ready`=0 while `rst_n` is low.
- **Reset mid-operation:** asserting reset discards any held beat; `out_valid` drops immediately (asynchronous).

## Timing
- **Latency:** 1 cycle from input acceptance to `out_valid`.
- **Throughput:** 1 beat per cycle when `out_ready` is held high.
- **Simultaneous drain and load:** in a FULL cycle with `out_ready`=1 and a request present, the old beat leaves and the new beat loads on the same edge. No bubble.
- **Fairness (round robin):** with all N channels continuously valid, the grant sequence is 0,1,…,N-1,0,… and each channel waits at most N-1 grants.
- **Data stability:** `out_data` and `out_sel` are stable while `out_valid`=1 and `out_ready`=0.
- **Reset release:** first grant is possible in the first cycle after `rst_n` deasserts.

## Structure
- **Shared package `mux_pkg`:**
  - Constants `ARB_FIXED`=0 and `ARB_RR`=1.
  - Function `sel_w(n)` returning max(1, $clog2(n)).
- **Sub-module `rr_arbiter`:**
  - Combinational.
  - Parameters N, MODE.
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `gnt[N]`, encoded `gnt_idx`, `any`.
- **Top level:** `chan_arb_mux` contains the output register, `ptr` register, load-enable logic and the data mux, indexed by `gnt_idx`.

## Test plan
- **Reset:** N=4, WIDTH=4, assert `rst_n`=0 mid-beat → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0 immediately; after release, first grant goes to channel 0.
- **Round-robin fairness:** MODE=1, all four channels valid with data 0xA,0xB,0xC,0xD, `out_ready`=1 → outputs A,B,C,D,A… with `out_sel` 0,1,2,3,0…, one per cycle, starting one cycle after the first accept.
- **Fixed priority:** MODE=0, channels 1 and 3 valid continuously → channel 1 always granted; channel 3 never granted until channel 1 drops.
- **Back-pressure:** FULL with `out_ready`=0 for 5 cycles → `in_ready`=0, `out_data`/`out_sel` unchanged; on `out_ready`=1, drain and next load occur on the same edge.
- **Non-power-of-2 wrap:** N=3, MODE=1, only channels 0 and 2 valid, `ptr`=2 → grants 2,0,2,0; `ptr` never reaches 3.
- **Idle:** no `in_valid` with `out_ready`=1 → `out_valid` falls the next cycle; `ptr` and `out_sel` are unchanged.
